// File: rtl/fos_pkg.sv
// Shared widths, FSM state type and Booth digit decode for the first-order
// all-pole inverse filter.
package fos_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned COEF_W  = 11;
    localparam int unsigned DIGITS  = (COEF_W + 1) / 2;
    localparam int unsigned CNT_W   = $clog2(DIGITS);
    localparam int unsigned SHIFT_W = CNT_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        OUT
    } state_t;

    typedef logic signed [2:0] booth_digit_t;

    // Radix-4 Booth recoding of {b[2i+1], b[2i], b[2i-1]} into {-2..+2}.
    function automatic booth_digit_t booth_decode(input logic [2:0] triplet);
        booth_digit_t digit;
        unique case (triplet)
            3'b000, 3'b111: digit = 3'b000;
            3'b001, 3'b010: digit = 3'b001;
            3'b011:         digit = 3'b010;
            3'b100:         digit = 3'b110;
            3'b101, 3'b110: digit = 3'b111;
            default:        digit = 3'b000;
        endcase
        return digit;
    endfunction

endpackage

// File: rtl/booth_r4_step.sv
// One radix-4 Booth partial product: digit(triplet) * y_prev, shifted left,
// truncated to DATA_W bits.
module booth_r4_step
    import fos_pkg::*;
(
    input  logic [2:0]         triplet,
    input  logic [DATA_W-1:0]  y_prev,
    input  logic [SHIFT_W-1:0] shift,
    output logic [DATA_W-1:0]  pp
);

    booth_digit_t      digit;
    logic [DATA_W-1:0] mag;
    logic [DATA_W-1:0] signed_mag;

    always_comb begin
        digit = booth_decode(triplet);
        mag   = '0;
        // Digit encodings: +-1 have bit0 set, +-2 have bits[1:0] = 2'b10.
        if (digit[0]) begin
            mag = y_prev;
        end else if (digit[1]) begin
            mag = y_prev << 1;
        end
        signed_mag = digit[2] ? -mag : mag;
        pp         = signed_mag << shift;
    end

endmodule

// File: rtl/fos_inverse_seq.sv
// Inverse of y[n] = x[n] + a1*y[n-1]: x[n] = y[n] - a1*y[n-1], with the
// product built by an iterative radix-4 Booth multiplier, one digit per cycle.
module fos_inverse_seq
    import fos_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] y_in,
    input  logic [COEF_W-1:0] a1,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] x_out
);

    state_t state_q, state_d;

    logic [DATA_W-1:0]   y_prev_q;
    logic [DATA_W-1:0]   y_cur_q;
    logic [DATA_W-1:0]   acc_q;
    logic [DATA_W-1:0]   x_out_q;
    logic [COEF_W-1:0]   a1_q;
    logic [CNT_W-1:0]    cnt_q;

    logic [2*DIGITS:0]   a1_pad;
    logic [2*DIGITS:0]   a1_sh;
    logic [2:0]          triplet;
    logic [SHIFT_W-1:0]  shift;
    logic [DATA_W-1:0]   pp;
    logic [DATA_W-1:0]   acc_sum;
    logic                last_digit;

    // Sign-extend to 2*DIGITS bits and append the implicit bit -1 = 0.
    assign a1_pad     = {{(2 * DIGITS - COEF_W){a1_q[COEF_W-1]}}, a1_q, 1'b0};
    assign shift      = {cnt_q, 1'b0};
    assign a1_sh      = a1_pad >> shift;
    assign triplet    = a1_sh[2:0];
    assign acc_sum    = acc_q + pp;
    assign last_digit = (cnt_q == CNT_W'(DIGITS - 1));

    booth_r4_step u_booth_r4_step (
        .triplet (triplet),
        .y_prev  (y_prev_q),
        .shift   (shift),
        .pp      (pp)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid)   state_d = MUL;
            MUL:     if (last_digit) state_d = OUT;
            OUT:     if (out_ready)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == OUT);
        x_out     = x_out_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            y_prev_q <= '0;
            y_cur_q  <= '0;
            acc_q    <= '0;
            x_out_q  <= '0;
            a1_q     <= '0;
            cnt_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        y_cur_q <= y_in;
                        a1_q    <= a1;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                MUL: begin
                    acc_q <= acc_sum;
                    if (last_digit) begin
                        x_out_q <= y_cur_q - acc_sum;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                OUT: begin
                    // y[n-1] advances only once the consumer has taken x[n].
                    if (out_ready) y_prev_q <= y_cur_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fos_inverse_seq.sv
// Scoreboard bench for fos_inverse_seq: directed cases, random round trip
// through a forward recursion model, backpressure and mid-run reset.
module tb_fos_inverse_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] y_in = '0;
    logic [10:0] a1 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] x_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ready_mode = 1;  // 0 random, 1 always ready, 2 manual
    int accept_edge = -1;
    logic prev_ov = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] fw_yprev;

    fos_inverse_seq dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y_in      (y_in),
        .a1        (a1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_out     (x_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] sext(input logic [10:0] a);
        return {{21{a[10]}}, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Offer one sample; the expected output is queued when it is accepted.
    task automatic send(input logic [31:0] y, input logic [10:0] c, input logic [31:0] exp,
                        input int max_gap);
        int waited = 0;
        repeat ($urandom_range(0, max_gap)) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        y_in     = y;
        a1       = c;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 100) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: got no in_ready expected accept within 100 cycles");
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        y_in     = $urandom;
        a1       = 11'($urandom);
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 300) begin
            @(posedge clk);
            w++;
        end
        #1;
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) out_ready = 1'($urandom_range(0, 1));
            else if (ready_mode == 1) out_ready = 1'b1;
        end
    end

    // Monitor: latency of each out_valid rise, and data on each output handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_ov = 1'b0;
                continue;
            end
            if (in_valid && in_ready) accept_edge = cyc + 1;
            if (out_valid && !prev_ov) check("latency", 32'(cyc - accept_edge), 32'd6);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h expected no output", x_out);
                end else begin
                    check("x_out", x_out, exp_q.pop_front());
                end
            end
            prev_ov = out_valid;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] x, y, bp_y, bp_exp;
        logic [10:0] c;
        int w;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_x_out", x_out, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        send(32'd100, 11'd5, 32'd100, 0);
        send(32'd520, 11'd5, 32'd20, 2);
        send(32'd3, 11'd0, 32'd3, 1);
        send(32'd0, 11'h400, 32'd3072, 1);
        send(32'h7FFF_FFFF, 11'd0, 32'h7FFF_FFFF, 1);
        send(32'd0, 11'd2, 32'd2, 1);
        drain();

        // Round trip: forward recursion feeds the DUT, which must return x.
        fw_yprev   = 32'd0;
        ready_mode = 0;
        for (int i = 0; i < 200; i++) begin
            x        = $urandom;
            c        = 11'($urandom_range(0, 2047));
            y        = x + sext(c) * fw_yprev;
            fw_yprev = y;
            send(y, c, x, 3);
        end
        drain();

        // Backpressure with a competing input offer.
        ready_mode = 2;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        bp_y   = $urandom;
        bp_exp = bp_y - sext(11'h7FD) * fw_yprev;
        send(bp_y, 11'h7FD, bp_exp, 0);
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!out_valid && w < 20);
        check("bp_reach_out", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        y_in     = 32'd123;
        a1       = 11'd1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_x_out", x_out, bp_exp);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_idle_in_ready", 32'(in_ready), 32'd1);
        check("bp_idle_out_valid", 32'(out_valid), 32'd0);
        check("bp_queue_empty", 32'(exp_q.size()), 32'd0);
        fw_yprev   = bp_y;
        ready_mode = 1;

        // Reset while the multiplier is on digit 3.
        @(posedge clk);
        #1;
        send(32'd55, 11'd7, 32'd0, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        send(32'd9, 11'd3, 32'd9, 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fos_inverse_seq.md
# fos_inverse_seq

Sequential inverse (analysis) filter for the first-order all-pole recursion y[n] = x[n] + a1·y[n-1]. It recovers x[n] = y[n] − a1·y[n-1] from the filtered stream. The product is formed by an iterative radix-4 Booth multiplier that retires one digit per cycle, which trades throughput for a single small adder. The block sits downstream of the recursive filter in the verification and decode path, behind valid/ready handshakes on both sides.

## Interface
- DATA_W, 32, sample width (two's complement)
- COEF_W, 11, coefficient width (two's complement); DIGITS = (COEF_W+1)/2 = 6
- clk  in  1  clock, all state on rising edge
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  y_in/a1 valid
- in_ready  out  1  block accepts input this cycle
- y_in  in  DATA_W  filtered sample y[n]
- a1  in  COEF_W  signed coefficient, sampled with y_in
- out_valid  out  1  x_out valid
- out_ready  in  1  consumer accepts x_out
- x_out  out  DATA_W  recovered sample x[n]

## Operation
- Registers: y_prev (last accepted y, reset 0), y_cur, a1_q, acc (DATA_W), digit counter cnt (0..DIGITS-1), x_out register, 3-state FSM.
- IDLE: in_ready=1. On in_valid&in_ready: y_cur<=y_in, a1_q<=a1, acc<=0, cnt<=0, go MUL.
- MUL: in_ready=0. Each cycle decode Booth digit cnt from the triplet {a1_q[2cnt+1], a1_q[2cnt], a1_q[2cnt-1]}, with a1_q sign-extended to 2·DIGITS bits and bit −1 = 0. The digit value is in {−2,−1,0,+1,+2}. acc <= acc + (digit·y_prev) << 2cnt, modulo 2^DATA_W. On cnt=DIGITS-1: x_out <= y_cur − (updated acc), go OUT.
- OUT: out_valid=1, x_out held stable. On out_ready: y_prev<=y_cur, go IDLE.
- Arithmetic: all sums and products are kept to the low DATA_W bits and wrap silently, with no saturation. This makes the block the exact modular inverse of a forward recursion that computes a1·y in the low DATA_W bits.
- a1 changes after acceptance are ignored. Each sample uses its own a1.
- Reset at any state: FSM to IDLE, out_valid=0, x_out=0, y_prev=0, acc=0, cnt=0. Any in-flight sample is discarded.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, x_out=0.
- in_ready is decoded combinationally from the state. out_valid is decoded from the state, and x_out is registered.
- Acceptance at edge t. MUL occupies the cycles after edges t..t+5. out_valid is first high after edge t+6, giving a latency of 6 cycles from the accept edge.
- Minimum period is 8 cycles per sample: 1 IDLE + 6 MUL + 1 OUT. in_ready is never high while a sample is in MUL or OUT, so there is no overlap.
- Backpressure: OUT holds indefinitely with x_out constant. y_prev updates only on the output handshake edge.
- No combinational path from in_valid or out_ready to any output.

## Structure
- Package fos_pkg holds:
  - DATA_W, COEF_W, DIGITS
  - state enum {IDLE, MUL, OUT}
  - Booth digit typedef (3-bit signed)
- Sub-module booth_r4_step (combinational) takes a triplet, y_prev and shift, and returns the signed partial product in DATA_W bits. It is instantiated once; the top level owns the FSM and registers.

## Test plan
- After reset: y_in=100, a1=5 gives x_out=100 (y_prev=0). Next y_in=520, a1=5 gives x_out=20. out_valid rises exactly 6 cycles after each accept edge.
- Negative coefficient: prior y=3, then y_in=0, a1=11'h400 (−1024) gives x_out=3072.
- Wrap: prior y=32'h7FFFFFFF, then y_in=0, a1=2 gives x_out=32'h00000002.
- Round trip: x=1..200 random, with a1 random over the full signed range per sample. Pass each through a behavioural forward model y=x+a1·y_prev mod 2^32, then into the DUT with random in_valid/out_ready gaps. The outputs must equal the original x bit-exactly and in order.
- Backpressure: hold out_ready=0 for 5 cycles in OUT. x_out and out_valid stay stable and in_ready stays 0, with no second accept despite in_valid=1. On release the handshake completes and IDLE follows on the next cycle.
- Reset mid-MUL at cnt=3: the next cycle shows out_valid=0 and in_ready=1. Then y_in=9, a1=3 gives x_out=9, confirming y_prev was cleared.
